robot_mission_ctrl: RTL and testbench
=====================================

ROBOT_MISSION_CTRL -- requirements
Module: robot_mission_ctrl

Interface
REQ-001 SHALL have parameter MOVE_LIMIT, default 1000, max front steps per mission (16-bit).
REQ-002 SHALL have parameter TURN_LIMIT, default 8, consecutive turns before stuck fault.
REQ-003 SHALL have parameter IDLE_LIMIT, default 4, consecutive no-command cycles meaning mission complete.
REQ-004 SHALL have parameter RST_CYCLES, default 2, robot reset hold length in cycles.
REQ-005 SHALL have ports: clock  in  1  system clock; reset  in  1  asynchronous, active-low.
REQ-006 SHALL have ports: start  in  1  begin mission; abort  in  1  cancel mission / clear fault.
REQ-007 SHALL have ports: robot_front, robot_turn, robot_remove  in  1 each  robot command outputs.
REQ-008 SHALL have port robot_rst_n  out  1  active-low reset to the robot FSM, driven from a dedicated flop.
REQ-009 SHALL have ports: busy  out  1; done  out  1  one-cycle pulse; fault  out  1; fault_code  out  2.
REQ-010 SHALL have ports: move_count  out  16; remove_count  out  8.

Function
REQ-011 SHALL implement states IDLE, RESET_ROBOT, RUN, DONE, FAULT.
REQ-012 robot_rst_n SHALL be 1 exactly in cycles where state==RUN, 0 in all other states.
REQ-013 busy SHALL be 1 in RESET_ROBOT and RUN, else 0.
REQ-014 IDLE: start=1 -> RESET_ROBOT; move_count, remove_count, turn streak, idle count cleared to 0 on that edge.
REQ-015 RESET_ROBOT: held exactly RST_CYCLES cycles, then RUN.
REQ-016 RUN: commands sampled every posedge; robot_front=1 -> move_count+1, turn streak=0, idle count=0.
REQ-017 RUN: robot_turn=1 -> turn streak+1, idle count=0.
REQ-018 RUN: robot_remove=1 -> remove_count+1 saturating at 255, idle count=0, turn streak unchanged.
REQ-019 RUN: all commands 0 -> idle count+1; first RUN cycle (robot in its reset-exit state, outputs 0) counts as idle.
REQ-020 RUN exit checks on the sampled cycle, priority highest first: >1 command high -> FAULT code 11; move_count would reach MOVE_LIMIT -> FAULT code 10; turn streak would reach TURN_LIMIT -> FAULT code 01; idle count would reach IDLE_LIMIT -> DONE.
REQ-021 Counter updates of the exiting cycle SHALL still be applied (move_count may equal MOVE_LIMIT in FAULT).
REQ-022 DONE: done=1 for that single cycle; next state IDLE unconditionally.
REQ-023 FAULT: fault=1, fault_code held; sticky; start ignored; abort=1 -> IDLE, fault=0, fault_code=00.
REQ-024 abort=1 in RESET_ROBOT or RUN -> IDLE next edge, no done pulse, counters retained.
REQ-025 abort has priority over start and over all RUN exit checks in the same cycle.
REQ-026 start while busy SHALL be ignored.
REQ-027 Counters SHALL retain values in IDLE/DONE/FAULT for readout until next accepted start.
REQ-028 fault_code SHALL be 00 whenever fault=0.

Reset
REQ-029 reset=0 SHALL asynchronously force state IDLE, robot_rst_n=0, busy=0, done=0, fault=0, fault_code=00, move_count=0, remove_count=0, internal counters 0.
REQ-030 After reset release, first state change SHALL occur at a posedge where start=1.
REQ-031 reset mid-RUN SHALL drop robot_rst_n to 0 immediately (asynchronous).

Verification
REQ-032 start pulse, then robot drives front 5 cycles, then 0s -> robot_rst_n high from cycle 3 after start, DONE after 1+5+... idle streak of 4, move_count=5, one done pulse, busy 0 after.
REQ-033 RUN with robot_turn=1 constantly -> FAULT code 01 after 8 turn cycles, robot_rst_n=0, fault sticky under start; abort -> IDLE, fault_code=00.
REQ-034 MOVE_LIMIT=10, robot_front=1 constantly -> FAULT code 10, move_count=10.
REQ-035 robot_front=1 and robot_remove=1 same cycle -> FAULT code 11 even if turn streak also at limit.
REQ-036 robot_remove pulsed 300 times interleaved with front -> remove_count=255 saturated, no fault.
REQ-037 abort and idle-limit in same RUN cycle -> IDLE, done stays 0; reset asserted mid-RESET_ROBOT -> all outputs at reset values before next edge.

Source files
------------

// File: rtl/robot_mission_ctrl.sv
// ---------------------------------------------------------------------------
// robot_mission_ctrl
//
// Sequences one robot mission: it holds the robot in reset for RST_CYCLES,
// lets it run while counting its commands, and ends the mission on an idle
// streak (done), on a command-protocol violation, on the move budget being
// used up, or on a run of consecutive turns (fault).
//
// Ports
//   clock          system clock
//   reset          asynchronous, active-low reset
//   start          begin a mission (ignored while busy or faulted)
//   abort          cancel the running mission, or clear a fault
//   robot_front    robot command: step forward
//   robot_turn     robot command: turn
//   robot_remove   robot command: remove an object
//   robot_rst_n    active-low reset to the robot; high only while running
//   busy           mission in progress (robot reset or running)
//   done           one-cycle pulse when a mission completes normally
//   fault          sticky fault flag, cleared only by abort
//   fault_code     11 multiple commands, 10 move limit, 01 stuck turning
//   move_count     forward steps in the current or last mission
//   remove_count   removals in the current or last mission (saturates)
// ---------------------------------------------------------------------------
module robot_mission_ctrl #(
    parameter int MOVE_LIMIT = 1000,
    parameter int TURN_LIMIT = 8,
    parameter int IDLE_LIMIT = 4,
    parameter int RST_CYCLES = 2
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        start,
    input  logic        abort,
    input  logic        robot_front,
    input  logic        robot_turn,
    input  logic        robot_remove,
    output logic        robot_rst_n,
    output logic        busy,
    output logic        done,
    output logic        fault,
    output logic [1:0]  fault_code,
    output logic [15:0] move_count,
    output logic [7:0]  remove_count
);

    localparam logic [15:0] MOVE_LIM = 16'(MOVE_LIMIT);
    localparam logic [15:0] TURN_LIM = 16'(TURN_LIMIT);
    localparam logic [15:0] IDLE_LIM = 16'(IDLE_LIMIT);
    localparam logic [15:0] RST_LAST = 16'(RST_CYCLES - 1);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_RESET_ROBOT,
        ST_RUN,
        ST_DONE,
        ST_FAULT
    } state_t;

    state_t      state, state_n;
    logic [1:0]  code_n;
    logic [15:0] move_n;
    logic [7:0]  remove_n;
    logic [15:0] turn_streak, turn_n;
    logic [15:0] idle_count, idle_n;
    logic [15:0] rst_cnt, rst_cnt_n;
    logic [1:0]  cmd_cnt;

    assign cmd_cnt = {1'b0, robot_front} + {1'b0, robot_turn} + {1'b0, robot_remove};

    // Next-state and next-counter decode.
    always_comb begin
        // NOTE: every variable gets a default first so no path leaves it
        // unassigned; otherwise synthesis would infer a latch.
        state_n   = state;
        code_n    = fault_code;
        move_n    = move_count;
        remove_n  = remove_count;
        turn_n    = turn_streak;
        idle_n    = idle_count;
        rst_cnt_n = rst_cnt;

        unique case (state)
            ST_IDLE: begin
                if (start && !abort) begin
                    state_n   = ST_RESET_ROBOT;
                    move_n    = '0;
                    remove_n  = '0;
                    turn_n    = '0;
                    idle_n    = '0;
                    rst_cnt_n = '0;
                end
            end

            ST_RESET_ROBOT: begin
                if (abort)
                    state_n = ST_IDLE;
                else if (rst_cnt == RST_LAST)
                    state_n = ST_RUN;
                else
                    rst_cnt_n = rst_cnt + 16'd1;
            end

            ST_RUN: begin
                if (abort) begin
                    state_n = ST_IDLE;
                end else begin
                    // Counter updates of this cycle apply even when it exits.
                    if (robot_front) begin
                        move_n = move_count + 16'd1;
                        turn_n = '0;
                    end else if (robot_turn) begin
                        turn_n = turn_streak + 16'd1;
                    end
                    if (robot_remove && remove_count != 8'hFF)
                        remove_n = remove_count + 8'd1;
                    idle_n = (cmd_cnt == 2'd0) ? idle_count + 16'd1 : '0;

                    // Exit checks, highest priority first.
                    if (cmd_cnt > 2'd1) begin
                        state_n = ST_FAULT;
                        code_n  = 2'b11;
                    end else if (robot_front && move_count + 16'd1 == MOVE_LIM) begin
                        state_n = ST_FAULT;
                        code_n  = 2'b10;
                    end else if (robot_turn && turn_streak + 16'd1 == TURN_LIM) begin
                        state_n = ST_FAULT;
                        code_n  = 2'b01;
                    end else if (cmd_cnt == 2'd0 && idle_count + 16'd1 == IDLE_LIM) begin
                        state_n = ST_DONE;
                    end
                end
            end

            ST_DONE: state_n = ST_IDLE;

            ST_FAULT: begin
                if (abort) begin
                    state_n = ST_IDLE;
                    code_n  = 2'b00;
                end
            end

            default: state_n = ST_IDLE;
        endcase
    end

    // State, counters and registered outputs. Outputs are decoded from the
    // next state so each one comes straight from its own flop.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state        <= ST_IDLE;
            robot_rst_n  <= 1'b0;
            busy         <= 1'b0;
            done         <= 1'b0;
            fault        <= 1'b0;
            fault_code   <= 2'b00;
            move_count   <= '0;
            remove_count <= '0;
            turn_streak  <= '0;
            idle_count   <= '0;
            rst_cnt      <= '0;
        end else begin
            // NOTE: non-blocking assignments so every flop samples the
            // pre-edge values regardless of statement order.
            state        <= state_n;
            robot_rst_n  <= (state_n == ST_RUN);
            busy         <= (state_n == ST_RESET_ROBOT) || (state_n == ST_RUN);
            done         <= (state_n == ST_DONE);
            fault        <= (state_n == ST_FAULT);
            fault_code   <= code_n;
            move_count   <= move_n;
            remove_count <= remove_n;
            turn_streak  <= turn_n;
            idle_count   <= idle_n;
            rst_cnt      <= rst_cnt_n;
        end
    end

endmodule

// File: tb/tb_robot_mission_ctrl.sv
// ---------------------------------------------------------------------------
// tb_robot_mission_ctrl
//
// Directed bench for robot_mission_ctrl. A table of {inputs, expected
// outputs} records covers the basic mission flow; hand-written sequences
// cover faults, saturation, abort priority and asynchronous reset.
// A second instance with MOVE_LIMIT=10 shares the inputs for the move-limit
// case.
// ---------------------------------------------------------------------------
module tb_robot_mission_ctrl;

    logic        clock;
    logic        reset;
    logic        start, abort, robot_front, robot_turn, robot_remove;

    logic        robot_rst_n, busy, done, fault;
    logic [1:0]  fault_code;
    logic [15:0] move_count;
    logic [7:0]  remove_count;

    logic        m_robot_rst_n, m_busy, m_done, m_fault;
    logic [1:0]  m_fault_code;
    logic [15:0] m_move_count;
    logic [7:0]  m_remove_count;

    int n_vec  = 0;
    int n_miss = 0;

    robot_mission_ctrl dut (
        .clock        (clock),
        .reset        (reset),
        .start        (start),
        .abort        (abort),
        .robot_front  (robot_front),
        .robot_turn   (robot_turn),
        .robot_remove (robot_remove),
        .robot_rst_n  (robot_rst_n),
        .busy         (busy),
        .done         (done),
        .fault        (fault),
        .fault_code   (fault_code),
        .move_count   (move_count),
        .remove_count (remove_count)
    );

    robot_mission_ctrl #(.MOVE_LIMIT(10)) dut_m (
        .clock        (clock),
        .reset        (reset),
        .start        (start),
        .abort        (abort),
        .robot_front  (robot_front),
        .robot_turn   (robot_turn),
        .robot_remove (robot_remove),
        .robot_rst_n  (m_robot_rst_n),
        .busy         (m_busy),
        .done         (m_done),
        .fault        (m_fault),
        .fault_code   (m_fault_code),
        .move_count   (m_move_count),
        .remove_count (m_remove_count)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // Packed view: {robot_rst_n, busy, done, fault, fault_code, move, remove}
    logic [29:0] act, act_m;
    assign act   = {robot_rst_n, busy, done, fault, fault_code, move_count, remove_count};
    assign act_m = {m_robot_rst_n, m_busy, m_done, m_fault, m_fault_code,
                    m_move_count, m_remove_count};

    function automatic logic [29:0] o(input bit rn, input bit b, input bit d,
                                      input bit f, input bit [1:0] c,
                                      input int mv, input int rm);
        return {rn, b, d, f, c, mv[15:0], rm[7:0]};
    endfunction

    task automatic check(input string name, input logic [29:0] got,
                         input logic [29:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_miss++;
            $display("FAIL %s: got %h expected %h", name, got, exp);
        end
    endtask

    // Inputs change 1 time unit after the edge; outputs are checked there too.
    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic set_in(input logic [4:0] v);
        {start, abort, robot_front, robot_turn, robot_remove} = v;
    endtask

    task automatic do_reset();
        set_in(5'b00000);
        reset = 1'b0;
        repeat (2) @(posedge clock);
        #1;
        check("reset_state", act, o(0, 0, 0, 0, 2'b00, 0, 0));
        check("reset_state_m", act_m, o(0, 0, 0, 0, 2'b00, 0, 0));
        reset = 1'b1;
    endtask

    // Accept start and advance to the first RUN cycle (RST_CYCLES = 2).
    task automatic enter_run();
        set_in(5'b10000);
        step();
        set_in(5'b00000);
        step();
        step();
    endtask

    typedef struct {
        logic [4:0]  stim;   // {start, abort, front, turn, remove}
        logic [29:0] exp;
    } vec_t;

    vec_t vecs[$];

    task automatic add(input logic [4:0] s, input logic [29:0] e);
        vecs.push_back('{s, e});
    endtask

    initial begin
        reset = 1'b0;
        set_in(5'b00000);

        // ---- Table: basic mission, readout, restart, abort ----
        add(5'b00000, o(0, 0, 0, 0, 2'b00, 0, 0));  // no start: stay idle
        add(5'b10000, o(0, 1, 0, 0, 2'b00, 0, 0));  // start -> robot reset
        add(5'b10000, o(0, 1, 0, 0, 2'b00, 0, 0));  // start while busy ignored
        add(5'b00000, o(1, 1, 0, 0, 2'b00, 0, 0));  // -> RUN
        add(5'b00000, o(1, 1, 0, 0, 2'b00, 0, 0));  // first RUN cycle idle=1
        for (int k = 1; k <= 5; k++)
            add(5'b00100, o(1, 1, 0, 0, 2'b00, k, 0));
        add(5'b00000, o(1, 1, 0, 0, 2'b00, 5, 0));  // idle 1
        add(5'b00000, o(1, 1, 0, 0, 2'b00, 5, 0));  // idle 2
        add(5'b00000, o(1, 1, 0, 0, 2'b00, 5, 0));  // idle 3
        add(5'b00000, o(0, 0, 1, 0, 2'b00, 5, 0));  // idle 4 -> DONE pulse
        add(5'b00000, o(0, 0, 0, 0, 2'b00, 5, 0));  // IDLE, count retained
        add(5'b10000, o(0, 1, 0, 0, 2'b00, 0, 0));  // restart clears counts
        add(5'b00000, o(0, 1, 0, 0, 2'b00, 0, 0));
        add(5'b00000, o(1, 1, 0, 0, 2'b00, 0, 0));
        add(5'b00001, o(1, 1, 0, 0, 2'b00, 0, 1));  // remove
        add(5'b00010, o(1, 1, 0, 0, 2'b00, 0, 1));  // turn
        add(5'b01000, o(0, 0, 0, 0, 2'b00, 0, 1));  // abort: no done, retained
        add(5'b11000, o(0, 0, 0, 0, 2'b00, 0, 1));  // abort beats start in IDLE
        add(5'b00000, o(0, 0, 0, 0, 2'b00, 0, 1));

        do_reset();
        for (int i = 0; i < vecs.size(); i++) begin
            set_in(vecs[i].stim);
            step();
            check($sformatf("vec%0d", i), act, vecs[i].exp);
        end

        // ---- Constant turning -> stuck fault, sticky, abort clears ----
        do_reset();
        set_in(5'b10000);
        step();
        set_in(5'b00010);
        step();
        step();
        check("turn_run", act, o(1, 1, 0, 0, 2'b00, 0, 0));
        for (int i = 1; i <= 7; i++) begin
            step();
            check($sformatf("turn_%0d", i), act, o(1, 1, 0, 0, 2'b00, 0, 0));
        end
        step();
        check("turn_fault", act, o(0, 0, 0, 1, 2'b01, 0, 0));
        set_in(5'b10000);
        step();
        check("fault_sticky", act, o(0, 0, 0, 1, 2'b01, 0, 0));
        set_in(5'b01000);
        step();
        check("fault_abort", act, o(0, 0, 0, 0, 2'b00, 0, 0));

        // ---- Move limit (MOVE_LIMIT = 10 instance) ----
        do_reset();
        set_in(5'b10000);
        step();
        set_in(5'b00100);
        step();
        step();
        for (int k = 1; k <= 9; k++) begin
            step();
            check($sformatf("move_m_%0d", k), act_m, o(1, 1, 0, 0, 2'b00, k, 0));
        end
        step();
        check("move_limit_m", act_m, o(0, 0, 0, 1, 2'b10, 10, 0));
        check("move_nolimit", act, o(1, 1, 0, 0, 2'b00, 10, 0));
        set_in(5'b01000);
        step();

        // ---- Multiple commands beat a turn streak at its limit ----
        do_reset();
        enter_run();
        set_in(5'b00010);
        repeat (7) step();
        check("streak7", act, o(1, 1, 0, 0, 2'b00, 0, 0));
        set_in(5'b00111);
        step();
        check("multi_cmd", {27'd0, fault, fault_code}, {27'd0, 1'b1, 2'b11});
        set_in(5'b01000);
        step();

        // ---- Remove saturation interleaved with front ----
        do_reset();
        enter_run();
        for (int i = 0; i < 300; i++) begin
            set_in(5'b00001);
            step();
            set_in(5'b00100);
            step();
        end
        check("remove_sat", act, o(1, 1, 0, 0, 2'b00, 300, 255));
        set_in(5'b00000);
        repeat (3) step();
        check("sat_idle3", act, o(1, 1, 0, 0, 2'b00, 300, 255));
        step();
        check("sat_done", act, o(0, 0, 1, 0, 2'b00, 300, 255));
        step();
        check("sat_after", act, o(0, 0, 0, 0, 2'b00, 300, 255));

        // ---- Abort in the same cycle as the idle limit ----
        do_reset();
        enter_run();
        repeat (3) step();
        check("idle3", act, o(1, 1, 0, 0, 2'b00, 0, 0));
        set_in(5'b01000);
        step();
        check("abort_idle", act, o(0, 0, 0, 0, 2'b00, 0, 0));
        set_in(5'b00000);
        step();
        check("abort_nodone", act, o(0, 0, 0, 0, 2'b00, 0, 0));

        // ---- Asynchronous reset mid-RESET_ROBOT and mid-RUN ----
        do_reset();
        set_in(5'b10000);
        step();
        set_in(5'b00000);
        check("in_rr", act, o(0, 1, 0, 0, 2'b00, 0, 0));
        #2 reset = 1'b0;
        #1 check("async_rr", act, o(0, 0, 0, 0, 2'b00, 0, 0));
        step();
        reset = 1'b1;
        set_in(5'b10000);
        step();
        set_in(5'b00100);
        step();
        step();
        step();
        check("run_pre", act, o(1, 1, 0, 0, 2'b00, 1, 0));
        #2 reset = 1'b0;
        #1 check("async_run", act, o(0, 0, 0, 0, 2'b00, 0, 0));
        set_in(5'b00000);
        step();
        reset = 1'b1;

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
